// File: rtl/ifft4_serial.sv
// 4-point inverse FFT on complex Q4.4 samples, computed with one time-shared radix-2
// butterfly over four cycles; valid/ready handshakes on input and output vectors.
module ifft4_serial #(
    parameter int DATA_W = 8,
    parameter bit SCALE  = 1'b1
) (
    input  logic                  clk1,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [4*DATA_W-1:0]   Xk_vect_real,
    input  logic [4*DATA_W-1:0]   Xk_vect_imag,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [4*DATA_W-1:0]   Xn_vect_real,
    output logic [4*DATA_W-1:0]   Xn_vect_imag,
    output logic                  busy
);

    typedef logic signed [DATA_W-1:0] samp_t;
    typedef logic signed [DATA_W:0]   wide_t;
    typedef enum logic [2:0] {IDLE, BF0, BF1, BF2, BF3, OUT} state_t;

    state_t                r_state;
    samp_t                 r_re [4];
    samp_t                 r_im [4];
    logic                  r_out_valid;
    logic [4*DATA_W-1:0]   r_xn_re;
    logic [4*DATA_W-1:0]   r_xn_im;

    logic [1:0]            w_ia;
    logic [1:0]            w_ib;
    samp_t                 w_a_re, w_a_im, w_b_re, w_b_im;
    wide_t                 w_bb_re, w_bb_im;
    wide_t                 w_sum_re, w_sum_im, w_dif_re, w_dif_im;
    samp_t                 w_s_re, w_s_im, w_d_re, w_d_im;

    // Floor halving (arithmetic shift) or plain wrap back to the sample width.
    function automatic samp_t scale(input wide_t v);
        if (SCALE)
            return samp_t'(v[DATA_W:1]);
        else
            return samp_t'(v[DATA_W-1:0]);
    endfunction

    always_comb begin
        w_ia = 2'd0;
        w_ib = 2'd2;
        case (r_state)
            BF1:     begin w_ia = 2'd1; w_ib = 2'd3; end
            BF2:     begin w_ia = 2'd0; w_ib = 2'd1; end
            BF3:     begin w_ia = 2'd2; w_ib = 2'd3; end
            default: begin w_ia = 2'd0; w_ib = 2'd2; end
        endcase
    end

    assign w_a_re = r_re[w_ia];
    assign w_a_im = r_im[w_ia];
    assign w_b_re = r_re[w_ib];
    assign w_b_im = r_im[w_ib];

    // BF3 rotates the second operand by +j; the negation is done one bit wider so -2^(W-1) is exact.
    always_comb begin
        w_bb_re = {w_b_re[DATA_W-1], w_b_re};
        w_bb_im = {w_b_im[DATA_W-1], w_b_im};
        if (r_state == BF3) begin
            w_bb_re = -{w_b_im[DATA_W-1], w_b_im};
            w_bb_im = {w_b_re[DATA_W-1], w_b_re};
        end
    end

    assign w_sum_re = {w_a_re[DATA_W-1], w_a_re} + w_bb_re;
    assign w_sum_im = {w_a_im[DATA_W-1], w_a_im} + w_bb_im;
    assign w_dif_re = {w_a_re[DATA_W-1], w_a_re} - w_bb_re;
    assign w_dif_im = {w_a_im[DATA_W-1], w_a_im} - w_bb_im;

    assign w_s_re = scale(w_sum_re);
    assign w_s_im = scale(w_sum_im);
    assign w_d_re = scale(w_dif_re);
    assign w_d_im = scale(w_dif_im);

    always_ff @(posedge clk1 or posedge rst) begin
        if (rst) begin
            r_state     <= IDLE;
            r_out_valid <= 1'b0;
            r_xn_re     <= '0;
            r_xn_im     <= '0;
            for (int k = 0; k < 4; k++) begin
                r_re[k] <= '0;
                r_im[k] <= '0;
            end
        end else begin
            case (r_state)
                IDLE: begin
                    if (in_valid) begin
                        for (int k = 0; k < 4; k++) begin
                            r_re[k] <= Xk_vect_real[4*DATA_W-1-k*DATA_W -: DATA_W];
                            r_im[k] <= Xk_vect_imag[4*DATA_W-1-k*DATA_W -: DATA_W];
                        end
                        r_state <= BF0;
                    end
                end
                BF0, BF1, BF2: begin
                    r_re[w_ia] <= w_s_re;
                    r_im[w_ia] <= w_s_im;
                    r_re[w_ib] <= w_d_re;
                    r_im[w_ib] <= w_d_im;
                    r_state    <= (r_state == BF0) ? BF1 : (r_state == BF1) ? BF2 : BF3;
                end
                BF3: begin
                    r_re[w_ia]  <= w_s_re;
                    r_im[w_ia]  <= w_s_im;
                    r_re[w_ib]  <= w_d_re;
                    r_im[w_ib]  <= w_d_im;
                    // x0 and x2 sit in slots 0 and 1 after BF2; x1/x3 come straight from this butterfly.
                    r_xn_re     <= {r_re[0], w_s_re, r_re[1], w_d_re};
                    r_xn_im     <= {r_im[0], w_s_im, r_im[1], w_d_im};
                    r_out_valid <= 1'b1;
                    r_state     <= OUT;
                end
                OUT: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_state     <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign in_ready     = (r_state == IDLE);
    assign busy         = (r_state != IDLE);
    assign out_valid    = r_out_valid;
    assign Xn_vect_real = r_xn_re;
    assign Xn_vect_imag = r_xn_im;

endmodule
